// File: rtl/rr_mux6_arbiter_if.sv
// rr_mux6_arbiter_if: requester/downstream bundle for the 6:1 round-robin arbiter (lock only with RR_ARB_LOCK_EN)
interface rr_mux6_arbiter_if;
  logic [5:0] req;
  logic [3:0] data0, data1, data2, data3, data4, data5;
  logic [2:0] sel;
  logic [5:0] grant;
  logic [5:0] req_ack;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef RR_ARB_LOCK_EN
  logic       lock;
  modport master (output req, data0, data1, data2, data3, data4, data5, out_ready, lock,
                  input sel, grant, req_ack, out_data, out_valid);
  modport slave  (input req, data0, data1, data2, data3, data4, data5, out_ready, lock,
                  output sel, grant, req_ack, out_data, out_valid);
`else
  modport master (output req, data0, data1, data2, data3, data4, data5, out_ready,
                  input sel, grant, req_ack, out_data, out_valid);
  modport slave  (input req, data0, data1, data2, data3, data4, data5, out_ready,
                  output sel, grant, req_ack, out_data, out_valid);
`endif
endinterface

// File: rtl/rr_mux6_arbiter.sv
// rr_mux6_arbiter: round-robin arbiter driving a 6:1 nibble select with registered valid/ready output
// Optional burst lock feature enabled by defining RR_ARB_LOCK_EN.
module rr_mux6_arbiter (
  input logic clk,
  input logic reset,
  rr_mux6_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d, sel_q, sel_d, nptr, start, win;
  logic [3:0] data_q, data_d, t;
  logic [5:0] cand, sel_oh;
  logic [3:0] dv [8];
  logic hs, found, keep, busy;
  assign dv[0] = bus.data0;
  assign dv[1] = bus.data1;
  assign dv[2] = bus.data2;
  assign dv[3] = bus.data3;
  assign dv[4] = bus.data4;
  assign dv[5] = bus.data5;
  assign dv[6] = 4'd0;
  assign dv[7] = 4'd0;
  assign busy   = state_q == BUSY;
  assign sel_oh = 6'b1 << sel_q;
  assign hs     = busy & bus.out_ready;
  assign nptr   = sel_q == 3'd5 ? 3'd0 : sel_q + 3'd1;
`ifdef RR_ARB_LOCK_EN
  assign keep = hs & bus.lock & bus.req[sel_q];
`else
  assign keep = 1'b0;
`endif
  // on a handshake the just-served requester is masked and the search starts after it
  assign start = busy ? nptr : ptr_q;
  assign cand  = busy ? bus.req & ~sel_oh : bus.req;
  always_comb begin
    found = 1'b0;
    win = start;
    t = 4'd0;
    for (int k = 5; k >= 0; k--) begin
      t = {1'b0, start} + 4'(k);
      t = t >= 4'd6 ? t - 4'd6 : t;
      if (cand[t[2:0]]) begin
        found = 1'b1;
        win = t[2:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    data_d = data_q;
    if (keep)
      data_d = dv[sel_q];
    else if (!busy || hs) begin
      ptr_d = hs ? nptr : ptr_q;
      state_d = found ? BUSY : IDLE;
      sel_d = found ? win : sel_q;
      data_d = found ? dv[win] : data_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 3'd0;
      sel_q <= 3'd0;
      data_q <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      data_q <= data_d;
    end
  end
  assign bus.sel       = sel_q;
  assign bus.out_valid = busy;
  assign bus.out_data  = data_q;
  assign bus.grant     = busy ? sel_oh : 6'd0;
  assign bus.req_ack   = hs ? sel_oh : 6'd0;
endmodule

// File: tb/tb_rr_mux6_arbiter.sv
// tb_rr_mux6_arbiter: directed stimulus with a handshake scoreboard for rr_mux6_arbiter
module tb_rr_mux6_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rr_mux6_arbiter_if bus ();
  rr_mux6_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q [$];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [2:0] s, input logic [3:0] d);
    exp_q.push_back({s, d});
  endtask
  // monitor: every accepted word must match the oldest expected transfer
  always @(negedge clk) begin
    logic [6:0] e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {bus.sel, bus.out_data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_sel", bus.sel, e[6:4]);
        chk("xfer_data", bus.out_data, e[3:0]);
        chk("xfer_grant", bus.grant, 6'b1 << e[6:4]);
        chk("xfer_ack", bus.req_ack, 6'b1 << e[6:4]);
      end
    end else if (bus.req_ack != 6'd0) begin
      chk("spurious_ack", bus.req_ack, 0);
    end
  end
  initial begin
    bus.req = 6'h3F;
    bus.out_ready = 1'b0;
    {bus.data0, bus.data1, bus.data2, bus.data3, bus.data4, bus.data5} = 24'h123456;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    repeat (3) step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_data", bus.out_data, 0);
    reset = 1'b0;
    step();
    chk("pre_rst_busy", bus.out_valid, 1);
    chk("pre_rst_sel", bus.sel, 0);
    reset = 1'b1;
    bus.req = 6'd0;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ack", bus.req_ack, 0);
    step();
    chk("post_rst_idle", bus.out_valid, 0);
    bus.req = 6'b000100;
    bus.data2 = 4'hA;
    bus.out_ready = 1'b1;
    push(3'd2, 4'hA);
    push(3'd2, 4'hA);
    step();
    chk("single_grant", bus.grant, 6'b000100);
    chk("single_sel", bus.sel, 2);
    chk("single_data", bus.out_data, 4'hA);
    step();
    chk("repeat_bubble", bus.out_valid, 0);
    step();
    chk("repeat_regrant", bus.grant, 6'b000100);
    bus.req = 6'd0;
    step();
    bus.req = 6'b100000;
    bus.data5 = 4'd5;
    push(3'd5, 4'd5);
    step();
    bus.req = 6'd0;
    step();
    chk("ptr0_idle", bus.out_valid, 0);
    bus.req = 6'h3F;
    {bus.data5, bus.data4, bus.data3, bus.data2, bus.data1, bus.data0} = 24'h543210;
    for (int i = 0; i < 6; i++) push(3'(i), 4'(i));
    push(3'd0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rr_seq", bus.sel, i % 6);
      chk("rr_nobubble", bus.out_valid, 1);
    end
    bus.req = 6'd0;
    step();
    bus.req = 6'b010000;
    bus.data4 = 4'd4;
    push(3'd4, 4'd4);
    step();
    bus.req = 6'd0;
    step();
    bus.req = 6'b100001;
    bus.data5 = 4'd7;
    bus.data0 = 4'd3;
    bus.out_ready = 1'b0;
    push(3'd5, 4'd7);
    push(3'd0, 4'd3);
    step();
    chk("wrap_first", bus.sel, 5);
    bus.req = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      bus.data5 = 4'(9 + i);
      step();
      chk("bp_data", bus.out_data, 7);
      chk("bp_sel", bus.sel, 5);
      chk("bp_grant", bus.grant, 6'b100000);
    end
    bus.out_ready = 1'b1;
    step();
    chk("wrap_then0", bus.sel, 0);
    bus.req = 6'd0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_grant", bus.grant, 0);
      chk("idle_sel", bus.sel, 0);
    end
`ifdef RR_ARB_LOCK_EN
    bus.req = 6'b000011;
    bus.data1 = 4'hB;
    bus.data0 = 4'hC;
    bus.lock = 1'b1;
    push(3'd1, 4'hB);
    push(3'd1, 4'hB);
    push(3'd1, 4'hB);
    push(3'd0, 4'hC);
    step();
    chk("lock_first", bus.sel, 1);
    step();
    chk("lock_hold1", bus.sel, 1);
    step();
    chk("lock_hold2", bus.sel, 1);
    bus.lock = 1'b0;
    step();
    chk("lock_release", bus.sel, 0);
    bus.req = 6'd0;
    step();
    step();
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
